// File: rtl/count_snap_pkg.sv
// Shared definitions for the counter snapshot FIFO.
// Optional feature macro: SNAP_TAG_EN (adds an 8-bit sequence tag per entry).
package count_snap_pkg;

    localparam int WIDTH_DEF  = 64;
    localparam int TAG_W      = 8;
    localparam int DROP_W_DEF = 8;

    // Layout of one stored snapshot at the default counter width.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] cnt0;
        logic [WIDTH_DEF-1:0] cnt1;
`ifdef SNAP_TAG_EN
        logic [TAG_W-1:0]     tag;
`endif
    } snap_entry_t;

    // Number of storage bits one entry needs for a given counter width.
    function automatic int entry_width(input int w);
`ifdef SNAP_TAG_EN
        return 2 * w + TAG_W;
`else
        return 2 * w;
`endif
    endfunction

endpackage

// File: rtl/snap_fifo_mem.sv
// Register-array storage for the snapshot FIFO: one write port, one
// asynchronous read port so the head entry can be shown ahead.
module snap_fifo_mem #(
    parameter int ENTRY_W = 128,
    parameter int DEPTH   = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [DEPTH-1:0][ENTRY_W-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            // Capture the write data when this slot is addressed; contents survive reset.
            always_ff @(posedge clk) begin
                if (we && (waddr == ADDR_W'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entries[raddr];

endmodule

// File: rtl/count_snapshot_fifo.sv
// Captures {Output0, Output1} counter pairs on snap into a show-ahead FIFO,
// presents them over valid/ready and counts snapshots dropped while full.
// Optional feature macro: SNAP_TAG_EN (adds out_tag and a per-entry sequence tag).
module count_snapshot_fifo
    import count_snap_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = 4,
    parameter int DROP_W = DROP_W_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snap,
    input  logic [WIDTH-1:0]  Output0,
    input  logic [WIDTH-1:0]  Output1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_cnt0,
    output logic [WIDTH-1:0]  out_cnt1,
    output logic [PTR_W:0]    level,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_cnt
`ifdef SNAP_TAG_EN
    ,
    output logic [TAG_W-1:0]  out_tag
`endif
);

    localparam int ENTRY_W = entry_width(WIDTH);

    localparam logic [PTR_W:0]    LEVEL_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    LEVEL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE   = DROP_W'(1);

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     level_reg;
    logic [PTR_W:0]     level_next;
    logic [DROP_W-1:0]  drop_cnt_reg;
    logic               push;
    logic               pop;
    logic               drop;
    logic               we;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;

    // Occupancy flags come from the level count, never from pointer equality.
    assign empty     = (level_reg == '0);
    assign full      = (level_reg == LEVEL_FULL);
    assign out_valid = !empty;
    assign level     = level_reg;
    assign drop_cnt  = drop_cnt_reg;

    // A pop in the same cycle frees a slot, so a snap against a full FIFO still lands.
    assign pop  = out_valid & out_ready;
    assign push = snap & (!full | pop);
    assign drop = snap & full & !pop;
    assign we   = push & !reset;

    // Next occupancy: push and pop together leave the level unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase
    end

    // Pointers and level; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            level_reg <= level_next;
        end
    end

    // Saturating count of snapshots refused because the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
        end
    end

`ifdef SNAP_TAG_EN
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

    logic [TAG_W-1:0] tag_reg;

    // Sequence tag advances only on accepted pushes, so drops consume no tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_reg <= '0;
        end else if (push) begin
            tag_reg <= tag_reg + TAG_ONE;
        end
    end

    assign wdata   = {Output0, Output1, tag_reg};
    assign out_tag = empty ? '0 : rdata[TAG_W-1:0];
`else
    assign wdata = {Output0, Output1};
`endif

    // Head entry is shown ahead and forced to zero while nothing is stored.
    assign out_cnt0 = empty ? '0 : rdata[ENTRY_W-1 -: WIDTH];
    assign out_cnt1 = empty ? '0 : rdata[ENTRY_W-WIDTH-1 -: WIDTH];

    snap_fifo_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_reg),
        .wdata (wdata),
        .raddr (rd_ptr_reg),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Self-checking bench for count_snapshot_fifo: directed vector table,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_count_snapshot_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        snap;
    logic [63:0] Output0;
    logic [63:0] Output1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_cnt0;
    logic [63:0] out_cnt1;
    logic [2:0]  level;
    logic        full;
    logic        empty;
    logic [7:0]  drop_cnt;
`ifdef SNAP_TAG_EN
    logic [7:0]  out_tag;
`endif

    int checks = 0;
    int errors = 0;

    count_snapshot_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .snap      (snap),
        .Output0   (Output0),
        .Output1   (Output1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt0  (out_cnt0),
        .out_cnt1  (out_cnt1),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
`ifdef SNAP_TAG_EN
        ,
        .out_tag   (out_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of stored pairs plus drop and tag counters.
    typedef struct {
        logic [63:0] c0;
        logic [63:0] c1;
        int          tag;
    } ent_t;

    ent_t mq[$];
    int   m_drop = 0;
    int   m_tag  = 0;

    function automatic void model_step(bit r, bit s, bit rd, logic [63:0] a, logic [63:0] b);
        ent_t e;
        if (r) begin
            mq.delete();
            m_drop = 0;
            m_tag  = 0;
            return;
        end
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (s) begin
            if (mq.size() < DEPTH) begin
                e.c0 = a;
                e.c1 = b;
                e.tag = m_tag;
                mq.push_back(e);
                m_tag = (m_tag + 1) % 256;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic apply(bit r, bit s, bit rd, logic [63:0] a, logic [63:0] b);
        reset     = r;
        snap      = s;
        out_ready = rd;
        Output0   = a;
        Output1   = b;
        model_step(r, s, rd, a, b);
        @(posedge clk);
        #1;
        $display("txn rst=%0b snap=%0b rdy=%0b in=(%0d,%0d) -> valid=%0b head=(%0d,%0d) level=%0d drop=%0d",
                 r, s, rd, a, b, out_valid, out_cnt0, out_cnt1, level, drop_cnt);
    endtask

    task automatic check_model(string name);
        bit ne;
        ne = (mq.size() > 0);
        chk({name, ".valid"}, 64'(out_valid), 64'(ne));
        chk({name, ".cnt0"},  out_cnt0, ne ? mq[0].c0 : 64'd0);
        chk({name, ".cnt1"},  out_cnt1, ne ? mq[0].c1 : 64'd0);
        chk({name, ".level"}, 64'(level), 64'(mq.size()));
        chk({name, ".full"},  64'(full),  64'(mq.size() == DEPTH));
        chk({name, ".empty"}, 64'(empty), 64'(!ne));
        chk({name, ".drop"},  64'(drop_cnt), 64'(m_drop));
`ifdef SNAP_TAG_EN
        chk({name, ".tag"},   64'(out_tag), ne ? 64'(mq[0].tag) : 64'd0);
`endif
    endtask

    typedef struct {
        bit          r;
        bit          s;
        bit          rd;
        logic [63:0] o0;
        logic [63:0] o1;
        bit          ev;
        logic [63:0] ec0;
        logic [63:0] ec1;
        int          elev;
        int          edrop;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(bit r, bit s, bit rd, logic [63:0] o0, logic [63:0] o1,
                                 bit ev, logic [63:0] ec0, logic [63:0] ec1, int elev, int edrop);
        vec_t v;
        v.r = r; v.s = s; v.rd = rd; v.o0 = o0; v.o1 = o1;
        v.ev = ev; v.ec0 = ec0; v.ec1 = ec1; v.elev = elev; v.edrop = edrop;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b1; snap = 1'b0; out_ready = 1'b0; Output0 = '0; Output1 = '0;

        // Directed table: reset, single capture with hold, fill/drain, drops, reset mid-stream.
        addv(1, 0, 0, 0, 0,       0, 0, 0, 0, 0);
        addv(0, 1, 0, 5, 9,       1, 5, 9, 1, 0);
        for (int k = 0; k < 3; k++) addv(0, 0, 0, 0, 0, 1, 5, 9, 1, 0);
        addv(0, 0, 1, 0, 0,       0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) addv(0, 1, 0, 64'(k), 64'(10 * k), 1, 1, 10, k, 0);
        for (int k = 1; k <= 3; k++) addv(0, 0, 1, 0, 0, 1, 64'(k + 1), 64'(10 * (k + 1)), 4 - k, 0);
        addv(0, 0, 1, 0, 0,       0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) addv(0, 1, 0, 64'(100 + k), 64'(200 + k), 1, 100, 200, k + 1, 0);
        for (int d = 1; d <= 3; d++) addv(0, 1, 0, 7, 7, 1, 100, 200, 4, d);
        addv(0, 1, 1, 104, 204,   1, 101, 201, 4, 3);
        addv(0, 0, 1, 0, 0,       1, 102, 202, 3, 3);
        addv(1, 1, 0, 9, 9,       0, 0, 0, 0, 0);
        addv(0, 1, 0, 55, 66,     1, 55, 66, 1, 0);
        addv(0, 0, 1, 0, 0,       0, 0, 0, 0, 0);
        addv(0, 0, 1, 0, 0,       0, 0, 0, 0, 0);
        addv(0, 1, 1, 77, 88,     1, 77, 88, 1, 0);
        addv(0, 0, 1, 0, 0,       0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].rd, vecs[i].o0, vecs[i].o1);
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d.cnt0", i),  out_cnt0, vecs[i].ec0);
            chk($sformatf("vec%0d.cnt1", i),  out_cnt1, vecs[i].ec1);
            chk($sformatf("vec%0d.level", i), 64'(level), 64'(vecs[i].elev));
            chk($sformatf("vec%0d.full", i),  64'(full),  64'(vecs[i].elev == DEPTH));
            chk($sformatf("vec%0d.empty", i), 64'(empty), 64'(vecs[i].elev == 0));
            chk($sformatf("vec%0d.drop", i),  64'(drop_cnt), 64'(vecs[i].edrop));
`ifdef SNAP_TAG_EN
            chk($sformatf("vec%0d.tag", i), 64'(out_tag), mq.size() > 0 ? 64'(mq[0].tag) : 64'd0);
`endif
        end

        // Streaming: snap and ready every cycle, level settles at 1, head lags input by one.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            apply(0, 1, 1, 64'(1000 + i), 64'(2000 + i));
            chk($sformatf("stream%0d.level", i), 64'(level), 64'd1);
            chk($sformatf("stream%0d.cnt0", i),  out_cnt0, 64'(1000 + i));
        end
        check_model("stream_end");

        // Drop counter saturates at 255.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 64'(i), 64'(i));
        for (int i = 0; i < 260; i++) apply(0, 1, 0, 64'hDEAD, 64'hBEEF);
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        check_model("drop_sat_model");

`ifdef SNAP_TAG_EN
        // Tags run 0..255 and wrap, with every snap accepted and drained.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 1, 64'(i), 64'(i));
            chk($sformatf("tag_seq%0d", i), 64'(out_tag), 64'(i % 256));
        end
        // A dropped snap consumes no tag.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 64'(i), 64'(i));
        apply(0, 1, 0, 99, 99);
        chk("tag_drop.drop", 64'(drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) apply(0, 0, 1, 0, 0);
        apply(0, 1, 0, 5, 5);
        chk("tag_after_drop", 64'(out_tag), 64'd4);
`endif

        // Randomized traffic against the model.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r, s, rd;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 45);
            apply(r, s, rd, {$urandom, $urandom}, {$urandom, $urandom});
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
